// File: rtl/processor_pkg.sv
// Shared processor definitions: opcodes, condition codes, instruction field layout,
// register-file size and the loader FSM state type (CLEAR only with LOADER_CLEAR_EN).
package processor_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_LOAD       = 4'd1,
        OP_STORE      = 4'd2,
        OP_BRANCH     = 4'd3,
        OP_XOR        = 4'd4,
        OP_ADD        = 4'd5,
        OP_ROTATE     = 4'd6,
        OP_SHIFT      = 4'd7,
        OP_HALT       = 4'd8,
        OP_COMPLEMENT = 4'd9,
        OP_ONESCOUNT  = 4'd10,
        OP_MULTIPLY   = 4'd11
    } opcode_e;

    localparam logic [3:0] CC_ALWAYS = 4'd0;
    localparam logic [3:0] CC_ZERO   = 4'd1;
    localparam logic [3:0] CC_NZERO  = 4'd2;
    localparam logic [3:0] CC_NEG    = 4'd3;
    localparam logic [3:0] CC_POS    = 4'd4;
    localparam logic [3:0] CC_CARRY  = 4'd5;
    localparam logic [3:0] CC_NCARRY = 4'd6;
    localparam logic [3:0] CC_OVF    = 4'd7;
    localparam logic [3:0] CC_MAX    = CC_OVF;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int MODE_MSB = 27;
    localparam int MODE_LSB = 24;
    localparam int SRC_MSB  = 23;
    localparam int SRC_LSB  = 12;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 0;

    localparam int MODE_SRC_IMM = 3;
    localparam int MODE_DST_IMM = 2;

    localparam int NUM_REGS = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
`ifdef LOADER_CLEAR_EN
        S_CLEAR,
`endif
        S_DONE
    } ld_state_e;

    function automatic logic is_reg_dst_op(logic [3:0] op);
        case (op)
            OP_LOAD, OP_XOR, OP_ADD, OP_ROTATE, OP_SHIFT, OP_COMPLEMENT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_reg_src_op(logic [3:0] op);
        case (op)
            OP_STORE, OP_XOR, OP_ADD, OP_COMPLEMENT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Instruction-field handshake, memory write port and session status of the loader.
interface program_loader_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_mode;
    logic [11:0] in_src;
    logic [11:0] in_dst;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] word_count;

    modport master (
        output start, in_valid, in_opcode, in_mode, in_src, in_dst,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
    );

    modport slave (
        input  start, in_valid, in_opcode, in_mode, in_src, in_dst,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
    );
endinterface

// File: rtl/program_loader_instr_encoder.sv
// Combinational instruction packer: builds the 32-bit word and flags illegal field combos.
module instr_encoder
    import processor_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  mode_i,
    input  logic [11:0] src_i,
    input  logic [11:0] dst_i,
    output logic [31:0] word_o,
    output logic        invalid_o
);

    always_comb begin
        word_o    = '0;
        invalid_o = 1'b0;
        word_o[OP_MSB:OP_LSB]     = opcode_i;
        word_o[MODE_MSB:MODE_LSB] = mode_i;
        word_o[SRC_MSB:SRC_LSB]   = src_i;
        word_o[DST_MSB:DST_LSB]   = dst_i;
        // Only BRANCH uses the low mode bits (full condition code)
        if (opcode_i != OP_BRANCH)
            word_o[MODE_LSB+1:MODE_LSB] = 2'b00;
        case (opcode_i)
            OP_NOP, OP_HALT, OP_ONESCOUNT, OP_MULTIPLY: word_o[MODE_MSB:0] = '0;
            default: ;
        endcase

        if (opcode_i > OP_MULTIPLY)
            invalid_o = 1'b1;
        if (opcode_i == OP_BRANCH && mode_i > CC_MAX)
            invalid_o = 1'b1;
        if (is_reg_dst_op(opcode_i) && !mode_i[MODE_DST_IMM] && dst_i >= 12'(NUM_REGS))
            invalid_o = 1'b1;
        if (is_reg_src_op(opcode_i) && !mode_i[MODE_SRC_IMM] && src_i >= 12'(NUM_REGS))
            invalid_o = 1'b1;
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: accepts instruction fields, writes encoded words from BASE_ADDR upward.
// LOADER_CLEAR_EN adds a CLEAR phase zero-filling memory after HALT up to MAX_ADDR.
module program_loader
    import processor_pkg::*;
#(
    parameter int BASE_ADDR = 3,
    parameter int MAX_ADDR  = 4095
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.slave  bus
);

    localparam logic [11:0] BASE = 12'(BASE_ADDR);
    localparam logic [11:0] MAX  = 12'(MAX_ADDR);

    ld_state_e   state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [11:0] wc_q, wc_d;
    logic        err_q, err_d;
    logic        halt_q, halt_d;
    logic        in_ready, mem_we, done;
    logic [31:0] enc_word;
    logic        enc_invalid;

    instr_encoder u_enc (
        .opcode_i  (bus.in_opcode),
        .mode_i    (bus.in_mode),
        .src_i     (bus.in_src),
        .dst_i     (bus.in_dst),
        .word_o    (enc_word),
        .invalid_o (enc_invalid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wc_q    <= '0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wc_d     = wc_q;
        err_d    = err_q;
        halt_d   = halt_q;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_ACCEPT;
                addr_d  = BASE;
                wc_d    = '0;
                err_d   = 1'b0;
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (enc_invalid) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wdata_d = enc_word;
                        halt_d  = (bus.in_opcode == OP_HALT);
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                wc_d   = wc_q + 12'd1;
                if (halt_q) begin
`ifdef LOADER_CLEAR_EN
                    if (addr_q == MAX) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 12'd1;
                        wdata_d = '0;
                        state_d = S_CLEAR;
                    end
`else
                    state_d = S_DONE;
                    if (addr_q != MAX) addr_d = addr_q + 12'd1;
`endif
                end else if (addr_q == MAX) begin
                    // Out of memory: hold the address rather than wrap to 0
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 12'd1;
                    state_d = S_ACCEPT;
                end
            end
`ifdef LOADER_CLEAR_EN
            S_CLEAR: begin
                mem_we = 1'b1;
                if (addr_q == MAX) state_d = S_DONE;
                else               addr_d  = addr_q + 12'd1;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done;
    assign bus.error      = err_q;
    assign bus.word_count = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: directed and random load sessions against a write-list reference model.
module tb_program_loader;

    localparam int BASE = 3;
    localparam int MAXA = 12;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  mode;
        logic [11:0] src;
        logic [11:0] dst;
    } ins_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    wr_t  got[$];
    ins_t prog[$];

    program_loader_if bus ();

    program_loader #(.BASE_ADDR(BASE), .MAX_ADDR(MAXA)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.mem_we) got.push_back('{bus.mem_addr, bus.mem_wdata});
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding straight from the instruction-format rules: {invalid, word}
    function automatic logic [32:0] ref_word(input ins_t i);
        logic [31:0] w;
        logic bad;
        logic rdst, rsrc;
        w = {i.op, i.mode, i.src, i.dst};
        if (i.op != 4'd3) w[25:24] = 2'b00;
        if (i.op == 4'd0 || i.op == 4'd8 || i.op == 4'd10 || i.op == 4'd11) w[27:0] = '0;
        rdst = (i.op == 4'd1 || i.op == 4'd4 || i.op == 4'd5 || i.op == 4'd6 ||
                i.op == 4'd7 || i.op == 4'd9);
        rsrc = (i.op == 4'd2 || i.op == 4'd4 || i.op == 4'd5 || i.op == 4'd9);
        bad = (i.op > 4'd11) || (i.op == 4'd3 && i.mode > 4'd7) ||
              (rdst && !i.mode[2] && i.dst > 12'd4) ||
              (rsrc && !i.mode[3] && i.src > 12'd4);
        return {bad, w};
    endfunction

    task automatic send(input ins_t i);
        bit ok;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        bus.in_opcode = i.op;
        bus.in_mode   = i.mode;
        bus.in_src    = i.src;
        bus.in_dst    = i.dst;
        bus.in_valid  = 1'b1;
        bus.start     = ($urandom_range(0, 3) == 0);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (bus.in_ready) begin
                @(posedge clock);
                ok = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk("xfer_ready", 32'(ok), 32'd1);
    endtask

    task automatic run_session(input string name);
        wr_t exp[$];
        int  addr, wc, nx, g0, d0;
        bit  err, stop;
        logic [32:0] r;
        addr = BASE; wc = 0; nx = 0; err = 1'b0; stop = 1'b0;
        for (int k = 0; k < prog.size() && !stop; k++) begin
            nx++;
            r = ref_word(prog[k]);
            if (r[32]) begin
                err = 1'b1; stop = 1'b1;
            end else begin
                exp.push_back('{12'(addr), r[31:0]});
                wc++;
                if (prog[k].op == 4'd8) begin
`ifdef LOADER_CLEAR_EN
                    for (int a = addr + 1; a <= MAXA; a++) exp.push_back('{12'(a), 32'h0});
`endif
                    stop = 1'b1;
                end else if (addr == MAXA) begin
                    err = 1'b1; stop = 1'b1;
                end else begin
                    addr++;
                end
            end
        end
        g0 = got.size();
        d0 = done_cnt;
        @(negedge clock) bus.start = 1'b1;
        @(negedge clock) bus.start = 1'b0;
        for (int k = 0; k < nx; k++) send(prog[k]);
        for (int c = 0; c < 6000 && done_cnt == d0; c++) @(negedge clock);
        repeat (3) @(negedge clock);
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_nwrites"}, 32'(got.size() - g0), 32'(exp.size()));
        for (int k = 0; k < exp.size() && g0 + k < got.size(); k++) begin
            chk({name, "_waddr"}, 32'(got[g0+k].a), 32'(exp[k].a));
            chk({name, "_wdata"}, got[g0+k].d, exp[k].d);
        end
        chk({name, "_error"}, 32'(bus.error), 32'(err));
        chk({name, "_word_count"}, 32'(bus.word_count), 32'(wc));
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clock);
        chk({name, "_idle_hold_wc"}, 32'(bus.word_count), 32'(wc));
        chk({name, "_idle_hold_err"}, 32'(bus.error), 32'(err));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({name, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_done"}, 32'(bus.done), 32'd0);
        chk({name, "_error"}, 32'(bus.error), 32'd0);
        chk({name, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({name, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({name, "_word_count"}, 32'(bus.word_count), 32'd0);
    endtask

    initial begin
        int g0;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        bus.in_opcode = '0; bus.in_mode = '0; bus.in_src = '0; bus.in_dst = '0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clock);

        // STORE imm-src then HALT; anchor the model with the literal encodings
        prog = '{'{4'd2, 4'b1000, 12'd6, 12'd0}, '{4'd8, 4'd0, 12'd0, 12'd0}};
        g0 = got.size();
        run_session("store_halt");
        chk("store_literal", got[g0].d, 32'h28006000);
        chk("halt_literal", got[g0+1].d, 32'h80000000);

        prog = '{'{4'd12, 4'd0, 12'd0, 12'd0}};
        run_session("bad_opcode");
        prog = '{'{4'd1, 4'd0, 12'd0, 12'd5}};
        run_session("bad_dst");
        prog = '{'{4'd3, 4'd9, 12'd1, 12'd2}};
        run_session("bad_cc");

        prog.delete();
        for (int k = 0; k < 12; k++) prog.push_back('{4'd0, 4'd0, 12'd0, 12'd0});
        prog.push_back('{4'd8, 4'd0, 12'd0, 12'd0});
        run_session("overflow");

        for (int s = 0; s < 25; s++) begin
            ins_t t;
            prog.delete();
            for (int k = 0; k < $urandom_range(1, 13); k++) begin
                t.op   = 4'($urandom_range(0, 13));
                t.mode = 4'($urandom);
                t.src  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 6));
                t.dst  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 6));
                prog.push_back(t);
            end
            prog.push_back('{4'd8, 4'd0, 12'd0, 12'd0});
            run_session("rand");
        end

        // Abort mid-session: during CLEAR when present, otherwise in the WRITE cycle
        @(negedge clock) bus.start = 1'b1;
        @(negedge clock) bus.start = 1'b0;
`ifdef LOADER_CLEAR_EN
        send('{4'd8, 4'd0, 12'd0, 12'd0});
        repeat (3) @(negedge clock);
`else
        send('{4'd0, 4'd0, 12'd0, 12'd0});
`endif
        reset = 1'b1;
        #1;
        chk_reset_outputs("abort");
        g0 = got.size();
        repeat (10) @(negedge clock);
        chk("abort_no_writes", 32'(got.size() - g0), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        prog = '{'{4'd5, 4'b0100, 12'd3, 12'd100}, '{4'd8, 4'd0, 12'd0, 12'd0}};
        run_session("recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 3: first memory word address written by a session.
REQ-002 SHALL have parameter MAX_ADDR, default 4095: last writable memory word address.
REQ-003 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a load session; honoured only in IDLE.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): instruction-field handshake.
REQ-007 SHALL have port in_opcode, input, 4: opcode 0..11 (NOP, LOAD, STORE, BRANCH, XOR, ADD, ROTATE, SHIFT, HALT, COMPLEMENT, ONESCOUNT, MULTIPLY).
REQ-008 SHALL have port in_mode, input, 4: BRANCH condition code; for other opcodes, bit3 = source-immediate and bit2 = destination-immediate, bits1:0 ignored.
REQ-009 SHALL have ports in_src (input, 12: source address, immediate or signed count) and in_dst (input, 12: destination address or branch target).
REQ-010 SHALL have ports mem_we (output, 1), mem_addr (output, 12) and mem_wdata (output, 32): single-word memory write port.
REQ-011 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), error (output, 1, sticky until next start) and word_count (output, 12: words written this session).

Function
REQ-012 SHALL implement FSM states IDLE, ACCEPT, WRITE, CLEAR, DONE.
REQ-013 IDLE->ACCEPT on start; mem_addr <= BASE_ADDR; word_count, error <= 0; busy = 1 in every state except IDLE.
REQ-014 in_ready SHALL be 1 only in ACCEPT; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-015 On a transfer of a valid word: WRITE next cycle, mem_we = 1 for exactly that cycle, mem_wdata = {opcode, mode, src, dst}; throughput one word per 2 cycles.
REQ-016 Opcodes NOP, HALT, ONESCOUNT and MULTIPLY SHALL encode bits 27:0 as zero; for non-BRANCH opcodes, bits 25:24 SHALL be zero.
REQ-017 Validation: opcode > 11, BRANCH with in_mode > 7, register destination > 4 (LOAD, XOR, ADD, ROTATE, SHIFT, COMPLEMENT), or register source > 4 (STORE, XOR, ADD, COMPLEMENT with bit3 = 0) SHALL set error, suppress the write, and go to DONE.
REQ-018 After each write, mem_addr increments and word_count increments; WRITE->ACCEPT unless the written word was HALT.
REQ-019 Written HALT: WRITE->CLEAR if LOADER_CLEAR_EN is defined, else ->DONE.
REQ-020 Overflow: a non-HALT word written at MAX_ADDR SHALL set error and go to DONE (no wrap to 0).
REQ-021 DONE SHALL pulse done for one cycle, then return to IDLE; start while not in IDLE SHALL be ignored.
REQ-022 mem_addr, mem_wdata, word_count and error SHALL hold their values in IDLE.

Reset
REQ-023 On reset: state IDLE; in_ready, mem_we, busy, done, error = 0; mem_addr = 0; mem_wdata = 0; word_count = 0.
REQ-024 Reset mid-session SHALL abort immediately with no further mem_we pulse.

Configuration
REQ-025 With LOADER_CLEAR_EN defined: CLEAR writes 32'h0 to each address from (HALT address + 1) through MAX_ADDR, one per cycle (mem_we = 1 each cycle), then DONE; word_count excludes cleared words.
REQ-026 Without LOADER_CLEAR_EN: the CLEAR state and its logic SHALL be absent; HALT goes directly to DONE.

Structure
REQ-027 A shared package processor_pkg SHALL hold the opcode constants, condition-code constants, instruction field bit positions, and NUM_REGS = 5.
REQ-028 A combinational sub-module instr_encoder SHALL produce the encoded word and the invalid flag from the four field inputs.

Verification
REQ-029 Stimulus: start; transfer opcode 2, mode 4'b1000, src 6, dst 0. Response: mem_we at 3 with data 32'h28006000, word_count 1.
REQ-030 Stimulus: after REQ-029, transfer opcode 8. Response: write 32'h80000000 at 4; done pulses; without the macro, error = 0 and word_count = 2.
REQ-031 Stimulus: transfer opcode 12, or opcode 1 with dst 5. Response: no mem_we, error = 1, done pulses.
REQ-032 Stimulus: MAX_ADDR = 5; transfer three NOPs. Response: writes at 3, 4, 5, then error = 1 with no write at 6 or 0.
REQ-033 Stimulus: LOADER_CLEAR_EN defined, MAX_ADDR = 7; transfer HALT. Response: writes 0x80000000 at 3, then zeros at 4..7 on consecutive cycles, then done.
REQ-034 Stimulus: reset asserted during CLEAR. Response: all outputs at their reset values, with no further writes.
